// File: rtl/sram_cfg_loader_pkg.sv
// Shared state encoding and sizing helpers
// for the config SRAM loader.
package cfg_pkg;

  typedef enum logic [1:0] {
    LOAD_IDLE = 2'd0,
    LOAD_LOAD = 2'd1,
    LOAD_READ = 2'd2
  } cfg_state_t;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 1;

  // serial bits in one full load or readback
  localparam int TOTAL_BITS =
    DEF_DATA_WIDTH << DEF_ADDR_WIDTH;

  // bit counter width, never below one bit
  function automatic int cnt_width(
    input int dw
  );
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/sram_cfg_loader_shift_reg.sv
// Right-shifting word register: serial-in at
// the MSB, parallel load, serial-out at bit 0.
module cfg_shift_reg #(
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic                  shift_en,
  input  logic                  ser_in,
  input  logic [DATA_WIDTH-1:0] par_in,
  output logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] q_shift
);

  // q_shift is the word after one shift, so the
  // loader can write a word on its last bit
  generate
    if (DATA_WIDTH == 1) begin : g_one
      assign q_shift = ser_in;
    end else begin : g_wide
      assign q_shift =
        {ser_in, q[DATA_WIDTH-1:1]};
    end
  endgenerate

  // parallel load wins over shift
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load_en) begin
      q <= par_in;
    end else if (shift_en) begin
      q <= q_shift;
    end
  end

endmodule

// File: rtl/sram_cfg_loader.sv
// Serial config loader/readback controller
// for one config SRAM instance.
module sram_cfg_loader
  import cfg_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_load,
  input  logic                  start_read,
  input  logic                  cfg_in,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  cfg_out,
  output logic                  cfg_out_valid,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] sram_waddr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_raddr,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam int BW = cnt_width(DATA_WIDTH);
  localparam logic [BW-1:0] BIT_LAST =
    BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE = 1;
  localparam logic [ADDR_WIDTH:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST =
    '1;

  cfg_state_t state, state_nxt;

  // extra MSB flags the terminal count
  logic [ADDR_WIDTH:0]   addr;
  logic [BW-1:0]         bcnt;
  logic [DATA_WIDTH-1:0] sh_q;
  logic [DATA_WIDTH-1:0] sh_next;
  logic                  sh_load;
  logic                  sh_shift;
  logic                  sh_in;
  logic                  accept;
  logic                  bit_last;
  logic                  addr_end;

  assign addr_end  = addr[ADDR_WIDTH];
  assign bit_last  = (bcnt == BIT_LAST);
  assign cfg_ready = (state == LOAD_LOAD) &&
                     !addr_end;
  assign accept    = cfg_ready && cfg_valid;
  assign busy      = (state != LOAD_IDLE);
  assign sram_raddr =
    (state == LOAD_READ) ?
    addr[ADDR_WIDTH-1:0] : '0;
  assign cfg_out   = cfg_out_valid && sh_q[0];

  cfg_shift_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load_en (sh_load),
    .shift_en(sh_shift),
    .ser_in  (sh_in),
    .par_in  (sram_rdata),
    .q       (sh_q),
    .q_shift (sh_next)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state; load wins a simultaneous start
  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD_IDLE: begin
        if (start_load) begin
          state_nxt = LOAD_LOAD;
        end else if (start_read) begin
          state_nxt = LOAD_READ;
        end
      end
      LOAD_LOAD: begin
        if (addr_end) begin
          state_nxt = LOAD_IDLE;
        end
      end
      LOAD_READ: begin
        if (cfg_out_valid && bit_last &&
            addr_end) begin
          state_nxt = LOAD_IDLE;
        end
      end
      default: state_nxt = LOAD_IDLE;
    endcase
  end

  // shifter control: assemble on load,
  // reload/serialize on readback
  always_comb begin
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_in    = 1'b0;
    unique case (state)
      LOAD_LOAD: begin
        sh_shift = accept;
        sh_in    = cfg_in;
      end
      LOAD_READ: begin
        sh_load  = !cfg_out_valid ||
                   (bit_last && !addr_end);
        sh_shift = cfg_out_valid && !bit_last;
      end
      default: begin
        sh_load  = 1'b0;
      end
    endcase
  end

  // counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr          <= '0;
      bcnt          <= '0;
      sram_waddr    <= '0;
      sram_wdata    <= '0;
      sram_we       <= 1'b0;
      done          <= 1'b0;
      cfg_out_valid <= 1'b0;
    end else begin
      sram_we <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        LOAD_IDLE: begin
          if (start_load || start_read) begin
            addr <= '0;
            bcnt <= '0;
          end
        end
        LOAD_LOAD: begin
          if (accept) begin
            if (bit_last) begin
              sram_wdata <= sh_next;
              sram_waddr <= addr[ADDR_WIDTH-1:0];
              sram_we    <= 1'b1;
              addr       <= addr + ADDR_ONE;
              bcnt       <= '0;
              done       <=
                (addr[ADDR_WIDTH-1:0] ==
                 ADDR_LAST);
            end else begin
              bcnt <= bcnt + BIT_ONE;
            end
          end
        end
        LOAD_READ: begin
          if (!cfg_out_valid) begin
            cfg_out_valid <= 1'b1;
            addr          <= addr + ADDR_ONE;
            bcnt          <= '0;
          end else if (bit_last) begin
            if (addr_end) begin
              cfg_out_valid <= 1'b0;
              done          <= 1'b1;
            end else begin
              addr <= addr + ADDR_ONE;
              bcnt <= '0;
            end
          end else begin
            bcnt <= bcnt + BIT_ONE;
          end
        end
        default: begin
          sram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_cfg_loader.sv
// Directed bench for sram_cfg_loader with
// 1-bit and 4-bit word instances.
module tb_sram_cfg_loader;
  import cfg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  logic       a_sl, a_sr, a_ci, a_cv;
  logic       a_cr, a_co, a_cov;
  logic       a_busy, a_done, a_we;
  logic [3:0] a_waddr, a_raddr;
  logic [0:0] a_wdata, a_rdata;
  logic [0:0] a_mem [16];

  logic       b_sl, b_sr, b_ci, b_cv;
  logic       b_cr, b_co, b_cov;
  logic       b_busy, b_done, b_we;
  logic [3:0] b_waddr, b_raddr;
  logic [3:0] b_wdata, b_rdata;
  logic [3:0] b_mem [16];

  logic [15:0] pat  = 16'h5A3D;
  logic [15:0] pat3 = 16'h0FF1;
  logic [3:0]  nib [16] = '{
    4'hA, 4'h3, 4'h5, 4'hC, 4'hF, 4'h0,
    4'h9, 4'h6, 4'h1, 4'h8, 4'hE, 4'h7,
    4'h2, 4'hD, 4'h4, 4'hB};

  always @(posedge clk)
    if (a_we) a_mem[a_waddr] <= a_wdata;
  always @(posedge clk)
    if (b_we) b_mem[b_waddr] <= b_wdata;
  assign a_rdata = a_mem[a_raddr];
  assign b_rdata = b_mem[b_raddr];

  sram_cfg_loader #(
    .ADDR_WIDTH(4), .DATA_WIDTH(1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .start_load(a_sl), .start_read(a_sr),
    .cfg_in(a_ci), .cfg_valid(a_cv),
    .cfg_ready(a_cr), .cfg_out(a_co),
    .cfg_out_valid(a_cov), .busy(a_busy),
    .done(a_done), .sram_waddr(a_waddr),
    .sram_wdata(a_wdata), .sram_we(a_we),
    .sram_raddr(a_raddr), .sram_rdata(a_rdata)
  );

  sram_cfg_loader #(
    .ADDR_WIDTH(4), .DATA_WIDTH(4)
  ) dut_b (
    .clk(clk), .rst(rst),
    .start_load(b_sl), .start_read(b_sr),
    .cfg_in(b_ci), .cfg_valid(b_cv),
    .cfg_ready(b_cr), .cfg_out(b_co),
    .cfg_out_valid(b_cov), .busy(b_busy),
    .done(b_done), .sram_waddr(b_waddr),
    .sram_wdata(b_wdata), .sram_we(b_we),
    .sram_raddr(b_raddr), .sram_rdata(b_rdata)
  );

  task automatic test_reset();
    logic [14:0] va;
    logic [17:0] vb;
    rst = 1'b1;
    @(posedge clk); #1;
    va = {a_cr, a_co, a_cov, a_busy, a_done,
          a_we, a_waddr, a_wdata, a_raddr};
    vb = {b_cr, b_co, b_cov, b_busy, b_done,
          b_we, b_waddr, b_wdata, b_raddr};
    total++;
    if (va !== '0) begin
      bad++;
      $display("FAIL reset_a: got %h want 0", va);
    end
    total++;
    if (vb !== '0) begin
      bad++;
      $display("FAIL reset_b: got %h want 0", vb);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (a_busy !== 1'b0 || a_cr !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: busy=%b cr=%b want 0 0",
               a_busy, a_cr);
    end
  endtask

  task automatic test_load_b2b(
    input logic [15:0] p
  );
    int   k;
    logic acc;
    k = 0;
    a_sl = 1'b1;
    @(posedge clk); #1;
    a_sl = 1'b0;
    total++;
    if (a_busy !== 1'b1 || a_cr !== 1'b1) begin
      bad++;
      $display("FAIL load_enter: busy=%b cr=%b want 1 1",
               a_busy, a_cr);
    end
    for (int c = 0; c < TOTAL_BITS + 4; c++) begin
      acc  = (k < 16);
      a_cv = acc;
      a_ci = acc ? p[k] : 1'b0;
      @(posedge clk); #1;
      if (acc) k++;
      total++;
      if (a_we !== acc ||
          a_done !== (acc && k == 16)) begin
        bad++;
        $display("FAIL load_we: c=%0d we=%b done=%b want %b %b",
                 c, a_we, a_done, acc, acc && k == 16);
      end
      if (acc) begin
        total++;
        if (a_waddr !== 4'(k - 1) ||
            a_wdata[0] !== p[k-1]) begin
          bad++;
          $display("FAIL load_word: addr=%0d data=%b want %0d %b",
                   a_waddr, a_wdata, k - 1, p[k-1]);
        end
      end
      total++;
      if (a_cr !== (k < 16)) begin
        bad++;
        $display("FAIL load_ready: c=%0d cr=%b want %b",
                 c, a_cr, k < 16);
      end
    end
    a_cv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (a_mem[i][0] !== p[i]) begin
        bad++;
        $display("FAIL load_mem: [%0d]=%b want %b",
                 i, a_mem[i], p[i]);
      end
    end
    total++;
    if (a_busy !== 1'b0) begin
      bad++;
      $display("FAIL load_idle: busy=%b want 0", a_busy);
    end
  endtask

  task automatic test_readback(
    input logic [15:0] p
  );
    a_sr = 1'b1;
    @(posedge clk); #1;
    a_sr = 1'b0;
    total++;
    if (a_cov !== 1'b0 || a_busy !== 1'b1) begin
      bad++;
      $display("FAIL read_enter: cov=%b busy=%b want 0 1",
               a_cov, a_busy);
    end
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); #1;
      total++;
      if (a_cov !== (c < 16) ||
          a_done !== (c == 16)) begin
        bad++;
        $display("FAIL read_valid: c=%0d cov=%b done=%b want %b %b",
                 c, a_cov, a_done, c < 16, c == 16);
      end
      if (c < 16) begin
        total++;
        if (a_co !== p[c]) begin
          bad++;
          $display("FAIL read_bit: c=%0d got %b want %b",
                   c, a_co, p[c]);
        end
      end
    end
    total++;
    if (a_busy !== 1'b0) begin
      bad++;
      $display("FAIL read_idle: busy=%b want 0", a_busy);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [15:0] p2;
    logic [14:0] va;
    logic        exp;
    p2 = ~pat;
    a_sl = 1'b1;
    @(posedge clk); #1;
    a_sl = 1'b0;
    for (int k = 0; k < 5; k++) begin
      a_cv = 1'b1;
      a_ci = p2[k];
      @(posedge clk); #1;
      total++;
      if (a_done !== 1'b0) begin
        bad++;
        $display("FAIL abort_done: k=%0d done=%b want 0",
                 k, a_done);
      end
    end
    a_cv = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    va = {a_cr, a_co, a_cov, a_busy, a_done,
          a_we, a_waddr, a_wdata, a_raddr};
    total++;
    if (va !== '0) begin
      bad++;
      $display("FAIL abort_outputs: got %h want 0", va);
    end
    @(posedge clk); #1;
    total++;
    if (a_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_pulse: done=%b want 0", a_done);
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp = (i < 5) ? p2[i] : pat[i];
      total++;
      if (a_mem[i][0] !== exp) begin
        bad++;
        $display("FAIL abort_mem: [%0d]=%b want %b",
                 i, a_mem[i], exp);
      end
    end
    test_load_b2b(pat);
  endtask

  task automatic test_both_start();
    int   k;
    logic acc;
    a_sl = 1'b1;
    a_sr = 1'b1;
    @(posedge clk); #1;
    a_sl = 1'b0;
    a_sr = 1'b0;
    total++;
    if (a_busy !== 1'b1 || a_cr !== 1'b1) begin
      bad++;
      $display("FAIL both_load: busy=%b cr=%b want 1 1",
               a_busy, a_cr);
    end
    a_sr = 1'b1;
    @(posedge clk); #1;
    a_sr = 1'b0;
    @(posedge clk); #1;
    total++;
    if (a_cov !== 1'b0 || a_busy !== 1'b1 ||
        a_cr !== 1'b1 || a_we !== 1'b0) begin
      bad++;
      $display("FAIL read_ignored: cov=%b busy=%b cr=%b we=%b want 0 1 1 0",
               a_cov, a_busy, a_cr, a_we);
    end
    k = 0;
    for (int c = 0; c < 22; c++) begin
      acc  = (k < 16);
      a_cv = 1'b1;
      a_ci = acc ? pat3[k] : 1'b1;
      @(posedge clk); #1;
      if (acc) k++;
      total++;
      if (a_we !== acc || a_cov !== 1'b0) begin
        bad++;
        $display("FAIL both_we: c=%0d we=%b cov=%b want %b 0",
                 c, a_we, a_cov, acc);
      end
      if (acc) begin
        total++;
        if (a_waddr !== 4'(k - 1)) begin
          bad++;
          $display("FAIL both_addr: got %0d want %0d",
                   a_waddr, k - 1);
        end
      end
    end
    a_cv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (a_mem[i][0] !== pat3[i]) begin
        bad++;
        $display("FAIL both_mem: [%0d]=%b want %b",
                 i, a_mem[i], pat3[i]);
      end
    end
  endtask

  task automatic test_nibble_gaps();
    int   k;
    logic acc;
    logic wexp;
    k = 0;
    b_sl = 1'b1;
    @(posedge clk); #1;
    b_sl = 1'b0;
    for (int c = 0; c < 110; c++) begin
      acc = (k < 64) && (c % 7 != 2) &&
            (c % 7 != 5);
      b_cv = acc;
      b_ci = acc ? nib[k/4][k%4] : 1'b0;
      @(posedge clk); #1;
      if (acc) k++;
      wexp = acc && (k % 4 == 0);
      total++;
      if (b_we !== wexp ||
          b_done !== (wexp && k == 64)) begin
        bad++;
        $display("FAIL nib_we: c=%0d we=%b done=%b want %b %b",
                 c, b_we, b_done, wexp, wexp && k == 64);
      end
      if (wexp) begin
        total++;
        if (b_waddr !== 4'(k/4 - 1) ||
            b_wdata !== nib[k/4-1]) begin
          bad++;
          $display("FAIL nib_word: addr=%0d data=%h want %0d %h",
                   b_waddr, b_wdata, k/4 - 1, nib[k/4-1]);
        end
      end
    end
    b_cv = 1'b0;
    total++;
    if (k != 64) begin
      bad++;
      $display("FAIL nib_count: got %0d want 64", k);
    end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (b_mem[i] !== nib[i]) begin
        bad++;
        $display("FAIL nib_mem: [%0d]=%h want %h",
                 i, b_mem[i], nib[i]);
      end
    end
  endtask

  task automatic test_readback_nibble();
    logic exp;
    b_sr = 1'b1;
    @(posedge clk); #1;
    b_sr = 1'b0;
    for (int c = 0; c < 66; c++) begin
      @(posedge clk); #1;
      total++;
      if (b_cov !== (c < 64) ||
          b_done !== (c == 64)) begin
        bad++;
        $display("FAIL nib_valid: c=%0d cov=%b done=%b want %b %b",
                 c, b_cov, b_done, c < 64, c == 64);
      end
      if (c < 64) begin
        exp = nib[c/4][c%4];
        total++;
        if (b_co !== exp) begin
          bad++;
          $display("FAIL nib_bit: c=%0d got %b want %b",
                   c, b_co, exp);
        end
      end
    end
    total++;
    if (b_busy !== 1'b0) begin
      bad++;
      $display("FAIL nib_idle: busy=%b want 0", b_busy);
    end
  endtask

  initial begin
    rst  = 1'b1;
    a_sl = 1'b0; a_sr = 1'b0;
    a_ci = 1'b0; a_cv = 1'b0;
    b_sl = 1'b0; b_sr = 1'b0;
    b_ci = 1'b0; b_cv = 1'b0;
    test_reset();
    test_load_b2b(pat);
    test_readback(pat);
    test_reset_mid_load();
    test_readback(pat);
    test_both_start();
    test_readback(pat3);
    test_nibble_gaps();
    test_readback_nibble();
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
